// File: rtl/util_fifo_pkg.sv
// Shared helpers for the single-clock FIFO: width derivation and
// parameter legality checking, evaluated at elaboration time.
package util_fifo_pkg;

    // Ceiling log2, usable in constant expressions such as port ranges.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Occupancy counter width: one extra bit so that 0..DEPTH all fit.
    function automatic int cnt_width(input int depth);
        return clog2(depth) + 1;
    endfunction

    // Legal configuration: DEPTH a power of two of at least 4, and the
    // almost-empty level strictly below the almost-full level, which may
    // not exceed DEPTH.
    function automatic bit params_ok(input int depth, input int ae_thresh,
                                     input int af_thresh);
        bit ok;
        ok = (depth >= 4) && ((depth & (depth - 1)) == 0);
        ok = ok && (ae_thresh < af_thresh) && (af_thresh <= depth);
        return ok;
    endfunction

endpackage

// File: rtl/util_fifo_mem.sv
// DATA_W x DEPTH register array: one synchronous write port and one
// asynchronous read port. Contents are not reset; validity is tracked by
// the pointer/count logic in the FIFO top.
module util_fifo_mem
    import util_fifo_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [clog2(DEPTH)-1:0]   waddr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [clog2(DEPTH)-1:0]   raddr,
    output logic [DATA_W-1:0]         rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: store the word on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port is a plain combinational index of the array.
    assign rdata = mem[raddr];

endmodule

// File: rtl/util_sync_fifo.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through
// read mode, occupancy count, threshold flags and sticky error flags.
//
// Handshake: a write is taken on any edge where wr_en is high and the FIFO
// is not full (or a read is taken in the same cycle, freeing a slot); a
// read is taken on any edge where rd_en is high and the FIFO is not empty.
// Requests that cannot be taken are dropped and recorded in the sticky
// overflow/underflow flags; the producer/consumer are expected to watch
// full/empty rather than rely on back-pressure.
module util_sync_fifo
    import util_fifo_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int DEPTH     = 16,
    parameter int FWFT      = 0,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             din,
    input  logic                          rd_en,
    input  logic                          clr_err,
    output logic [DATA_W-1:0]             dout,
    output logic                          valid,
    output logic                          full,
    output logic                          almost_full,
    output logic                          empty,
    output logic                          almost_empty,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW    = clog2(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_THRESH);

    // Stop elaboration on an illegal configuration.
    generate
        if (!params_ok(DEPTH, AE_THRESH, AF_THRESH)) begin : g_bad_params
            $error("util_sync_fifo: illegal DEPTH/AE_THRESH/AF_THRESH combination");
        end
    endgenerate

    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_accept;
    logic              wr_accept;
    logic              ovf_evt;
    logic              udf_evt;

    util_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk    (clk),
        .we     (wr_accept),
        .waddr  (wr_ptr),
        .wdata  (din),
        .raddr  (rd_ptr),
        .rdata  (rd_data)
    );

    // Accept/error decode. A read frees a slot in the same cycle, so a
    // write at full is still taken when paired with a read. The write
    // enable is masked during reset so reset-cycle inputs never land.
    always_comb begin
        rd_accept = rd_en && !empty;
        wr_accept = !rst && wr_en && (!full || rd_accept);
        ovf_evt   = wr_en && full && !rd_en;
        udf_evt   = rd_en && empty;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_accept && !rd_accept) begin
                count <= count + CNT_W'(1);
            end else if (rd_accept && !wr_accept) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Status flags depend only on the registered count.
    always_comb begin
        full         = (count == FULL_LVL);
        empty        = (count == '0);
        almost_full  = (count >= AF_LVL);
        almost_empty = (count <= AE_LVL);
    end

    // Sticky error flags; a new event outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (udf_evt) begin
                underflow <= 1'b1;
            end else if (clr_err) begin
                underflow <= 1'b0;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always presented; rd_en acknowledges it.
            always_comb begin
                dout  = rd_data;
                valid = !empty;
            end
        end else begin : g_std
            // Registered read: dout loads on an accepted read and holds
            // otherwise; valid marks the cycle right after that read.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout  <= '0;
                    valid <= 1'b0;
                end else begin
                    valid <= rd_accept;
                    if (rd_accept) begin
                        dout <= rd_data;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: doc/util_sync_fifo.md
# util_sync_fifo

Parametrised single-clock FIFO: the next-generation replacement for the fixed 64-bit instruction FIFO in the ISA fetch path, reusable for any same-clock buffering in the accelerator. It adds configurable width and depth, a selectable standard or first-word-fall-through (FWFT) read mode, occupancy count, almost-full/almost-empty thresholds, and sticky overflow/underflow error flags.

## Interface
- DATA_W, 64, data word width in bits
- DEPTH, 16, number of entries; power of two, ≥ 4
- FWFT, 0, read mode: 0 = standard (registered read), 1 = first-word-fall-through
- AF_THRESH, DEPTH-2, `almost_full` asserts when count ≥ AF_THRESH
- AE_THRESH, 2, `almost_empty` asserts when count ≤ AE_THRESH
- clk  in  1  sole clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- din  in  DATA_W  write data
- rd_en  in  1  read request (standard) / pop acknowledge (FWFT)
- clr_err  in  1  clears the sticky error flags
- dout  out  DATA_W  read data
- valid  out  1  `dout` holds a word
- full / almost_full  out  1  occupancy flags
- empty / almost_empty  out  1  occupancy flags
- count  out  $clog2(DEPTH)+1  stored words, 0..DEPTH
- overflow / underflow  out  1  sticky error flags

## Operation
- Storage: DEPTH-entry array addressed by wrapping write and read pointers of $clog2(DEPTH) bits. `count` is a separate register, so full and empty are never ambiguous.
- Write is accepted when `wr_en && (!full || rd_accept)`. The word is stored at wr_ptr, which then increments modulo DEPTH.
- Read is accepted (`rd_accept`) when `rd_en && !empty`. rd_ptr increments modulo DEPTH.
- `count` update: +1 on write only, −1 on read only, unchanged when both or neither occur.
- Full with simultaneous wr_en and rd_en: both are accepted and count stays at DEPTH.
- Empty with simultaneous wr_en and rd_en: the write is accepted, the read is ignored, and `underflow` sets.
- `overflow` sets on wr_en while full without rd_en. The data is dropped and no state changes.
- `underflow` sets on rd_en while empty. No state changes.
- Both error flags are sticky until `clr_err`. If a set and `clr_err` occur in the same cycle, the set wins.
- Flags derive from registered `count`:
  - full = (count==DEPTH)
  - empty = (count==0)
  - almost_full = (count ≥ AF_THRESH)
  - almost_empty = (count ≤ AE_THRESH)
- Standard mode (FWFT=0):
  - On an accepted read, `dout` loads mem[rd_ptr] and `valid` is 1 for the following cycle only.
  - Otherwise `dout` holds its last value and `valid`=0.
- FWFT mode (FWFT=1):
  - `dout` = mem[rd_ptr] (combinational read of the array) and `valid` = !empty.
  - rd_en pops the presented word.
- Reset values:
  - count=0, pointers=0
  - empty=1, almost_empty=1, full=0, almost_full=0
  - valid=0, dout=0 (standard mode)
  - overflow=0, underflow=0
- Asserting rst mid-operation discards all contents. Inputs in the reset cycle are ignored.

## Timing
- Write at edge N: count, empty and full update after edge N. The word is readable from edge N+1 onward.
- Standard read latency is 1 cycle: rd_en sampled at edge M gives dout/valid after M.
- FWFT: the first word appears on dout the cycle after its write edge, with zero read latency.
- Throughput is one write and one read per cycle, sustained, in both modes.
- No combinational path from wr_en or rd_en to any flag output. A combinational path from rd_ptr to dout exists in FWFT mode only.

## Structure
- Package `util_fifo_pkg` holds:
  - the clog2 helper function
  - the `CNT_W` derivation
  - a parameter-legality check function (DEPTH power of two, AE_THRESH < AF_THRESH ≤ DEPTH)
- Sub-module `util_fifo_mem`: DATA_W×DEPTH register array with one synchronous write port and one asynchronous read port.
- Pointer, count, flag and output-mode logic live in `util_sync_fifo`.

## Test plan
- **Reset:** hold rst for 2 cycles with wr_en=rd_en=1 → all outputs at reset values, count=0.
- **Fill and overflow:** DEPTH=16, write 1..16 → full=1 after the 16th write and almost_full after the 14th. A 17th write of 99 → overflow=1, count=16. Draining reads 1..16 in order with no 99. `clr_err` → overflow=0.
- **Simultaneous write/read:**
  - At full: write 100 with rd_en → count stays 16, 100 appears after the 16 prior words.
  - At empty: same-cycle wr_en/rd_en with din=5 → underflow=1, count=1, the next read returns 5.
- **Wrap-around:** 40 back-to-back write+read pairs with din=1..40 at steady occupancy 3 → data in order, count constant at 3, no error flags.
- **FWFT mode:** write 7 → dout=7 and valid=1 on the next cycle with no rd_en. rd_en → empty=1.
- **Reset mid-operation:** assert rst at count=9 → count=0 and empty=1 next cycle. A subsequent write of 42 reads back as 42.
